// File: rtl/cd_seq_gen.sv
// Command-driven stimulus transmitter for the count-direction detector.
// Optional expected-flag model is compiled in with `define CD_SEQ_GEN_EXPECT_EN.
module cd_seq_gen #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             done,
  output logic             exp_valid,
  output logic             exp_incr,
  output logic             exp_decr,
  output logic             exp_error,
  output logic             dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and the initiator holds the command until then.
  typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

  localparam logic [1:0] MODE_INCR = 2'b00;
  localparam logic [1:0] MODE_DECR = 2'b01;
  localparam logic [1:0] MODE_JUMP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_t           state;
  logic [1:0]       mode;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] step_val;

  assign cmd_ready = reset && (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    step_val = data;
    case (mode)
      MODE_INCR: step_val = data + WIDTH'(1);
      MODE_DECR: step_val = data - WIDTH'(1);
      MODE_JUMP: step_val = data + WIDTH'(2);
      default:   step_val = data;
    endcase
  end

  // cnt holds the number of step beats still to drive after the current one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode       <= MODE_INCR;
      cnt        <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_valid <= 1'b0;
          done       <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            state      <= RUN;
            mode       <= cmd_mode;
            data       <= cmd_seed;
            data_valid <= 1'b1;
            if (cmd_mode == MODE_LOAD) begin
              cnt  <= '0;
              done <= 1'b1;
            end else begin
              cnt  <= cmd_len;
              done <= (cmd_len == '0);
            end
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            done       <= 1'b0;
          end else begin
            data <= step_val;
            cnt  <= cnt - LEN_W'(1);
            done <= (cnt == LEN_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CD_SEQ_GEN_EXPECT_EN
  logic [WIDTH-1:0] hist;
  logic             hist_ok;
  logic [WIDTH:0]   hist_w;
  logic [WIDTH:0]   data_w;
  logic             is_incr;
  logic             is_decr;

  // Direction compare is non-wrapping: 15 -> 0 is an error, not an increment.
  assign hist_w  = {1'b0, hist};
  assign data_w  = {1'b0, data};
  assign is_incr = (data_w == hist_w + (WIDTH+1)'(1));
  assign is_decr = (hist_w == data_w + (WIDTH+1)'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist      <= '0;
      hist_ok   <= 1'b0;
      exp_valid <= 1'b0;
      exp_incr  <= 1'b0;
      exp_decr  <= 1'b0;
      exp_error <= 1'b0;
    end else if (data_valid) begin
      hist      <= data;
      hist_ok   <= 1'b1;
      exp_valid <= hist_ok;
      exp_incr  <= hist_ok && is_incr;
      exp_decr  <= hist_ok && is_decr;
      exp_error <= hist_ok && !is_incr && !is_decr;
    end else begin
      exp_valid <= 1'b0;
      exp_incr  <= 1'b0;
      exp_decr  <= 1'b0;
      exp_error <= 1'b0;
    end
  end
`else
  assign exp_valid = 1'b0;
  assign exp_incr  = 1'b0;
  assign exp_decr  = 1'b0;
  assign exp_error = 1'b0;
`endif

endmodule

// File: tb/tb_cd_seq_gen.sv
// Bench for cd_seq_gen: directed test-plan steps plus random commands,
// checked cycle by cycle against a beat-list reference model.
module tb_cd_seq_gen;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic [W-1:0] cmd_seed;
  logic [3:0]   cmd_len;
  logic [W-1:0] data;
  logic         data_valid;
  logic         done;
  logic         exp_valid;
  logic         exp_incr;
  logic         exp_decr;
  logic         exp_error;
  logic         dbg_state;

  cd_seq_gen #(.WIDTH(W), .LEN_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_seed(cmd_seed), .cmd_len(cmd_len),
    .data(data), .data_valid(data_valid), .done(done),
    .exp_valid(exp_valid), .exp_incr(exp_incr), .exp_decr(exp_decr), .exp_error(exp_error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference model state
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic         m_busy;
  logic [W-1:0] m_last;
  int           m_hist;
  logic         m_hist_ok;
  logic         p_v, p_i, p_d, p_e;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy = 1'b0; m_last = '0; m_hist = 0; m_hist_ok = 1'b0;
    p_v = 1'b0; p_i = 1'b0; p_d = 1'b0; p_e = 1'b0;
  endtask

  // Whole beat list of a command, computed up front with modular arithmetic.
  task automatic push_beats(input logic [1:0] mode, input int seed, input int len);
    int v, step;
    v = seed;
    exp_q.push_back(W'(v));
    if (mode == 2'b11) return;
    step = (mode == 2'b00) ? 1 : (mode == 2'b01) ? -1 : 2;
    for (int k = 1; k <= len; k++) begin
      v = (v + step + 16) % 16;
      exp_q.push_back(W'(v));
    end
  endtask

  // One clock cycle: predict accept, advance, then check every output at the negedge.
  task automatic tick(output logic accepted);
    logic e_dv, e_done, e_ready, ev, ei, ed, ee;
    logic [W-1:0] e_data;
    int d;
    accepted = cmd_valid && reset && !m_busy;
    @(posedge clk);
    if (accepted) push_beats(cmd_mode, int'(cmd_seed), int'(cmd_len));
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e_data = exp_q.pop_front(); e_dv = 1'b1; e_done = (exp_q.size() == 0); e_ready = 1'b0;
      m_last = e_data;
    end else begin
      e_data = m_last; e_dv = 1'b0; e_done = 1'b0; e_ready = 1'b1;
    end
    m_busy = e_dv;
    chk("data", 8'(data), 8'(e_data));
    chk("data_valid", 8'(data_valid), 8'(e_dv));
    chk("done", 8'(done), 8'(e_done));
    chk("cmd_ready", 8'(cmd_ready), 8'(e_ready));
`ifdef CD_SEQ_GEN_EXPECT_EN
    ev = p_v; ei = p_i; ed = p_d; ee = p_e;
`else
    ev = 1'b0; ei = 1'b0; ed = 1'b0; ee = 1'b0;
`endif
    chk("exp_valid", 8'(exp_valid), 8'(ev));
    chk("exp_incr", 8'(exp_incr), 8'(ei));
    chk("exp_decr", 8'(exp_decr), 8'(ed));
    chk("exp_error", 8'(exp_error), 8'(ee));
    if (e_dv) begin
      d = int'(e_data);
      p_v = m_hist_ok;
      p_i = m_hist_ok && (d == m_hist + 1);
      p_d = m_hist_ok && (m_hist == d + 1);
      p_e = m_hist_ok && !p_i && !p_d;
      m_hist = d; m_hist_ok = 1'b1;
    end else begin
      p_v = 1'b0; p_i = 1'b0; p_d = 1'b0; p_e = 1'b0;
    end
  endtask

  // driver tasks
  task automatic send(input logic [1:0] mode, input logic [W-1:0] seed, input logic [3:0] len);
    logic acc;
    cmd_mode = mode; cmd_seed = seed; cmd_len = len; cmd_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) tick(acc);
    if (!acc) chk("accept_timeout", 8'd0, 8'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && m_busy; i++) tick(acc);
    if (m_busy) chk("drain_timeout", 8'd0, 8'd1);
    tick(acc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, 8'(data), 8'd0);
    chk({tag, "_dv"}, 8'(data_valid), 8'd0);
    chk({tag, "_done"}, 8'(done), 8'd0);
    chk({tag, "_ready"}, 8'(cmd_ready), 8'd0);
    chk({tag, "_exp"}, 8'({exp_valid, exp_incr, exp_decr, exp_error}), 8'd0);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_seed = '0; cmd_len = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    #1 chk("ready_after_rst", 8'(cmd_ready), 8'd1);
    idle(1);

    // test-plan directed commands
    send(2'b00, 4'd3, 4'd4);  drain();
    send(2'b01, 4'd1, 4'd3);  drain();
    send(2'b10, 4'd14, 4'd2); drain();
    send(2'b11, 4'd9, 4'd0);
    send(2'b00, 4'd10, 4'd1); drain();

    // reset in the middle of a run, at beat 2
    send(2'b00, 4'd0, 4'd10);
    idle(2);
    #1 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1 chk("ready_rel", 8'(cmd_ready), 8'd1);
    idle(1);
    send(2'b01, 4'd7, 4'd2); drain();

    // cmd_valid held through RUN with a different mode
    send(2'b00, 4'd5, 4'd3);
    send(2'b01, 4'd12, 4'd2); drain();

    // random commands with 0..2 idle cycles between them
    for (int n = 0; n < 30; n++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 2));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cd_seq_gen.md
# cd_seq_gen

Command-driven stimulus transmitter for the count-direction detector. It takes a command (mode, seed, length) over a valid/ready handshake and drives a stream of 4-bit data beats, one per clock, that step up, step down, or jump. It sits on the data side of the detector's interface. It also produces the incr/decr/error flags the detector must assert, aligned to the detector's registered output, so a bench or a system self-check can compare them directly.

## Interface
- WIDTH, 4: data width in bits.
- LEN_W, 4: width of the beat-count field.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  generator can accept a command (high only in IDLE).
- cmd_mode  in  2  00 INCR, 01 DECR, 10 JUMP (+2 per step), 11 LOAD (seed beat only).
- cmd_seed  in  WIDTH  value of the first beat.
- cmd_len  in  LEN_W  number of step beats after the seed beat (ignored for LOAD).
- data  out  WIDTH  beat value to the detector.
- data_valid  out  1  data is a live beat this cycle.
- done  out  1  one-cycle pulse, coincident with the last beat of a command.
- exp_valid  out  1  exp_* flags are meaningful this cycle.
- exp_incr, exp_decr, exp_error  out  1 each  predicted detector flags.

## Operation
- States: IDLE, RUN. A command is accepted when cmd_valid && cmd_ready at a rising edge. Accepting captures mode, seed and len, and moves to RUN.
- RUN beat 0 drives data = seed.
- Beat k (k = 1..len) drives:
  - INCR: data = previous beat + 1.
  - DECR: data = previous beat − 1.
  - JUMP: data = previous beat + 2.
- All data arithmetic is modulo 2^WIDTH: 15+1 → 0, 0−1 → 15, 15+2 → 1.
- LOAD emits beat 0 only.
- After the last beat, return to IDLE. cmd_ready is high the following cycle.
- When data_valid = 0, data holds the last driven value. Before any beat after reset, data = 0.
- cmd_valid during RUN is ignored. The command is not queued, and the initiator must hold it until cmd_ready.
- Expected-flag model:
  - The generator keeps `hist`, the last driven beat, plus `hist_ok`. `hist_ok` is cleared by reset and set by the first beat.
  - History persists across commands, matching the detector's behaviour.
  - For each beat d with hist_ok = 1, the cycle after that beat asserts exp_valid = 1 with:
    - exp_decr = (hist == d+1)
    - exp_incr = (hist == d−1)
    - exp_error otherwise
  - The compare is non-wrapping, computed at WIDTH+1 bits without modular reduction. So 15 → 0 and 0 → 15 predict exp_error.
  - Equal consecutive values predict exp_error.
  - The first beat after reset (hist_ok = 0) gives exp_valid = 0 the next cycle.
- Reset asserted at any time: state → IDLE; data, data_valid, done, exp_* → 0; hist_ok → 0; cmd_ready → 1 once reset deasserts. An in-flight command is discarded.

## Timing
- Accept at edge T: beat 0 is driven in cycle T+1, and beat k in cycle T+1+k.
- The last beat is in cycle T+1+len (T+1 for LOAD), with done = 1 in that same cycle.
- cmd_ready is 0 from cycle T+1 through the last beat, and 1 again in cycle T+2+len. The minimum inter-command gap is therefore one idle cycle.
- exp_* for a beat in cycle N appears in cycle N+1. exp_* is 0 whenever exp_valid = 0.
- Reset values: cmd_ready = 1 (while reset is released), data = 0, all other outputs 0.

## Configuration
- CD_SEQ_GEN_EXPECT_EN defined: the expected-flag model and the hist/hist_ok registers are compiled in, as specified above.
- Not defined: the model logic is removed, and exp_valid, exp_incr, exp_decr, exp_error are tied to 0. data, data_valid, done and cmd_ready timing are unchanged.

## Test plan
- After reset, send INCR seed 3, len 4, accepted at T. Required:
  - data 3,4,5,6,7 in cycles T+1..T+5, with done at T+5 and cmd_ready high at T+6.
  - exp_valid at T+3..T+6, each with exp_incr = 1.
- Send DECR seed 1, len 3. Required:
  - data 1,0,15,14.
  - exp: decr for 1→0, error for 0→15 (non-wrapping), decr for 15→14.
- Send JUMP seed 14, len 2. Required: data 14,0,2, with exp_error = 1 for both steps.
- Send LOAD seed 9, then immediately INCR seed 10, len 1. Required:
  - 9 is a single beat with done.
  - cmd_ready is low for one cycle.
  - The next accept gives data 10,11, with exp_incr for 9→10 across the command boundary and for 10→11.
- Assert reset mid-RUN at beat 2 of INCR seed 0, len 10. Required:
  - All outputs are 0 immediately, asynchronously.
  - After release, cmd_ready = 1.
  - The first new beat gives exp_valid = 0.
- Hold cmd_valid high during RUN with a different mode. Required: it is ignored until cmd_ready, then accepted exactly once.
